// File: rtl/shift_field_packer.sv
// Sequential field packer: field i = i << i (truncated to FIELD_W), one field per clock,
// MSB-first or LSB-first slot order, with a sticky truncation flag.
module shift_field_packer #(
  parameter int unsigned FIELD_W    = 10,
  parameter int unsigned NUM_FIELDS = 8,
  parameter int unsigned CNT_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          lsb_first,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_FIELDS*FIELD_W-1:0] result,
  output logic                          overflow
);

  localparam int unsigned VW = CNT_W + NUM_FIELDS;
  // Shifter width covers the full i << i and always leaves at least one bit above the field.
  localparam int unsigned XW = (VW > FIELD_W) ? VW : FIELD_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               busy_nx;
  logic               done_nx;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   slot;
  logic               lsb_q;
  logic [XW-1:0]      val;
  logic [FIELD_W-1:0] field;
  logic               field_ovf;

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    if (state_nx == RUN)  busy_nx = 1'b1;
    if (state_nx == DONE) done_nx = 1'b1;
  end

  always_comb begin
    val       = XW'(idx) << idx;
    field     = val[FIELD_W-1:0];
    field_ovf = |val[XW-1:FIELD_W];
    slot      = lsb_q ? idx : LAST - idx;
  end

  // Datapath: clear on accepted start, write one slot per RUN cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      lsb_q    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lsb_q    <= lsb_first;
            result   <= '0;
            overflow <= 1'b0;
            idx      <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NUM_FIELDS; k++) begin
            if (slot == CNT_W'(k)) result[k*FIELD_W +: FIELD_W] <= field;
          end
          if (field_ovf) overflow <= 1'b1;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
